// File: rtl/switch_debounce_stage.sv
// switch_debounce_stage
// Synchronizes and debounces eight slide switches. Every accepted change of
// the debounced value produces one event {changed_mask, new_value}, which is
// queued in a 4-entry FIFO for a downstream consumer.
//
// Event handshake: evt_valid is high while the FIFO holds at least one entry
// and evt_data shows the oldest entry. The entry is consumed on a rising edge
// where evt_valid && evt_ready. evt_data stays constant while
// evt_valid && !evt_ready. evt_ready while evt_valid is low has no effect.
module switch_debounce_stage #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [7:0]  sw_raw,
  output logic [7:0]  sw_stable,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [15:0] evt_data,
  output logic        evt_overflow,
  input  logic        clear_overflow
);

  // One spare bit above what DEBOUNCE_CYCLES-1 needs; the counter is cleared
  // at DEBOUNCE_CYCLES-1, so it never saturates.
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [7:0]    sync1;
  logic [7:0]    sync2;
  logic [CW-1:0] cnt      [8];
  logic [CW-1:0] cnt_next [8];
  logic [7:0]    stable_next;
  logic [7:0]    change_mask;

  logic          push_q;
  logic [15:0]   push_word_q;

  logic [15:0]   mem [4];
  logic [1:0]    wr_ptr;
  logic [1:0]    rd_ptr;
  logic [2:0]    count;
  logic          full;
  logic          pop;
  logic          do_push;
  logic          drop;

  // Two-flop synchronizer for the asynchronous switch levels.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sw_raw;
      sync2 <= sync1;
    end
  end

  // Per-bit debounce: count consecutive disagreeing cycles, flip on the last one.
  always_comb begin
    stable_next = sw_stable;
    for (int i = 0; i < 8; i++) begin
      cnt_next[i] = '0;
      if (sync2[i] != sw_stable[i]) begin
        if (cnt[i] == CNT_LAST) begin
          stable_next[i] = ~sw_stable[i];
        end else begin
          cnt_next[i] = cnt[i] + CW'(1);
        end
      end
    end
  end

  assign change_mask = stable_next ^ sw_stable;

  // Debounced value, counters and the registered event request.
  // The request register delays the FIFO write by one cycle, so evt_valid
  // rises the cycle after sw_stable changes.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      sw_stable   <= '0;
      push_q      <= 1'b0;
      push_word_q <= '0;
      for (int i = 0; i < 8; i++) cnt[i] <= '0;
    end else begin
      sw_stable   <= stable_next;
      push_q      <= |change_mask;
      push_word_q <= {change_mask, stable_next};
      for (int i = 0; i < 8; i++) cnt[i] <= cnt_next[i];
    end
  end

  assign full    = (count == 3'd4);
  assign evt_valid = (count != 3'd0);
  assign pop     = evt_valid & evt_ready;
  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign do_push = push_q & (~full | pop);
  assign drop    = push_q & full & ~pop;
  assign evt_data = evt_valid ? mem[rd_ptr] : 16'h0000;

  // FIFO storage; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk_clk) begin
    if (do_push) mem[wr_ptr] <= push_word_q;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)     rd_ptr <= rd_ptr + 2'd1;
      case ({do_push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow flag; a drop on the same edge as a clear keeps it set.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      evt_overflow <= 1'b0;
    end else if (drop) begin
      evt_overflow <= 1'b1;
    end else if (clear_overflow) begin
      evt_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_switch_debounce_stage.sv
// Bench for switch_debounce_stage with DEBOUNCE_CYCLES = 4.
// Stimulus pushes expected events into exp_q; the monitor pops and compares
// on every accepted handshake.
module tb_switch_debounce_stage;

  logic        clk_clk;
  logic        reset_reset_n;
  logic [7:0]  sw_raw;
  logic [7:0]  sw_stable;
  logic        evt_valid;
  logic        evt_ready;
  logic [15:0] evt_data;
  logic        evt_overflow;
  logic        clear_overflow;

  logic [15:0] exp_q[$];
  int          total;
  int          bad;

  switch_debounce_stage #(.DEBOUNCE_CYCLES(4)) dut (
    .clk_clk        (clk_clk),
    .reset_reset_n  (reset_reset_n),
    .sw_raw         (sw_raw),
    .sw_stable      (sw_stable),
    .evt_valid      (evt_valid),
    .evt_ready      (evt_ready),
    .evt_data       (evt_data),
    .evt_overflow   (evt_overflow),
    .clear_overflow (clear_overflow)
  );

  // Clock and time limit
  initial begin
    clk_clk = 1'b0;
    forever #5 clk_clk = ~clk_clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  // Advance n rising edges; inputs change and outputs are read 1 ns after.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset_reset_n  = 1'b0;
    sw_raw         = 8'h00;
    evt_ready      = 1'b0;
    clear_overflow = 1'b0;
    step(2);
    reset_reset_n = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      step(1);
      n++;
    end
    check(name, 16'(exp_q.size()), 16'd0);
  endtask

  // Apply a raw value and hold it long enough for its event to be queued.
  task automatic settle(input logic [7:0] v);
    sw_raw = v;
    step(8);
  endtask

  // Monitor: compare each accepted event against the head of exp_q
  always @(negedge clk_clk) begin
    if (reset_reset_n && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: got 0x%04h expected none", evt_data);
      end else begin
        check("event_data", evt_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    reset_reset_n  = 1'b0;
    sw_raw         = 8'h00;
    evt_ready      = 1'b0;
    clear_overflow = 1'b0;
    step(3);
    check("reset_stable",   16'(sw_stable), 16'h0000);
    check("reset_valid",    16'(evt_valid), 16'h0000);
    check("reset_data",     evt_data,       16'h0000);
    check("reset_overflow", 16'(evt_overflow), 16'h0000);
    reset_reset_n = 1'b1;
    step(2);

    // Single bit held: accepted on the 6th edge, event visible one cycle later
    sw_raw    = 8'h01;
    evt_ready = 1'b1;
    exp_q.push_back(16'h0101);
    step(5);
    check("single_stable_early", 16'(sw_stable), 16'h0000);
    check("single_valid_early",  16'(evt_valid), 16'h0000);
    step(1);
    check("single_stable_on_time", 16'(sw_stable), 16'h0001);
    check("single_valid_same_cycle", 16'(evt_valid), 16'h0000);
    step(1);
    check("single_valid_next_cycle", 16'(evt_valid), 16'h0001);
    wait_drain("single_drain");

    // Bouncing bit 3: 2-cycle pulses never reach the threshold
    do_reset();
    evt_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      sw_raw = (k % 2 == 0) ? 8'h08 : 8'h00;
      step(2);
      check("bounce_stable", 16'(sw_stable), 16'h0000);
    end
    check("bounce_valid", 16'(evt_valid), 16'h0000);
    sw_raw = 8'h08;
    exp_q.push_back(16'h0808);
    step(5);
    check("bounce_stable_early", 16'(sw_stable), 16'h0000);
    step(1);
    check("bounce_stable_final", 16'(sw_stable), 16'h0008);
    wait_drain("bounce_drain");
    step(10);
    check("bounce_single_event", 16'(evt_valid), 16'h0000);

    // Four bits change together: one event only
    do_reset();
    evt_ready = 1'b1;
    sw_raw = 8'hF0;
    exp_q.push_back(16'hF0F0);
    step(6);
    check("multi_stable", 16'(sw_stable), 16'h00F0);
    step(1);
    check("multi_valid", 16'(evt_valid), 16'h0001);
    step(1);
    check("multi_one_event", 16'(evt_valid), 16'h0000);
    wait_drain("multi_drain");

    // Overflow: five changes into a 4-entry FIFO with no consumer
    do_reset();
    exp_q.push_back(16'h0101);
    exp_q.push_back(16'h0203);
    exp_q.push_back(16'h0407);
    exp_q.push_back(16'h080F);
    settle(8'h01);
    check("ovf_not_yet", 16'(evt_overflow), 16'h0000);
    settle(8'h03);
    settle(8'h07);
    settle(8'h0F);
    check("ovf_full_no_flag", 16'(evt_overflow), 16'h0000);
    settle(8'h1F);
    check("ovf_flag", 16'(evt_overflow), 16'h0001);
    check("ovf_head_held", evt_data, 16'h0101);
    step(3);
    check("ovf_head_still_held", evt_data, 16'h0101);
    evt_ready = 1'b1;
    step(5);
    check("ovf_drained_valid", 16'(evt_valid), 16'h0000);
    wait_drain("ovf_drain");
    check("ovf_sticky", 16'(evt_overflow), 16'h0001);
    clear_overflow = 1'b1;
    step(1);
    clear_overflow = 1'b0;
    check("ovf_cleared", 16'(evt_overflow), 16'h0000);

    // Push and pop on the same edge while full
    do_reset();
    exp_q.push_back(16'h0101);
    exp_q.push_back(16'h0203);
    exp_q.push_back(16'h0407);
    exp_q.push_back(16'h080F);
    settle(8'h01);
    settle(8'h03);
    settle(8'h07);
    settle(8'h0F);
    sw_raw = 8'h1F;
    exp_q.push_back(16'h101F);
    step(6);
    evt_ready = 1'b1;
    step(1);
    evt_ready = 1'b0;
    check("pp_no_overflow", 16'(evt_overflow), 16'h0000);
    check("pp_valid", 16'(evt_valid), 16'h0001);
    check("pp_head", evt_data, 16'h0203);
    settle(8'h3F);
    check("pp_still_full", 16'(evt_overflow), 16'h0001);
    evt_ready = 1'b1;
    wait_drain("pp_drain");
    evt_ready = 1'b0;
    clear_overflow = 1'b1;
    step(1);
    clear_overflow = 1'b0;

    // Reset in the middle of a debounce with two events pending
    do_reset();
    settle(8'h01);
    settle(8'h03);
    sw_raw = 8'h07;
    step(4);
    reset_reset_n = 1'b0;
    step(1);
    check("midrst_stable",   16'(sw_stable), 16'h0000);
    check("midrst_valid",    16'(evt_valid), 16'h0000);
    check("midrst_overflow", 16'(evt_overflow), 16'h0000);
    check("midrst_data",     evt_data, 16'h0000);
    sw_raw = 8'h00;
    step(1);
    reset_reset_n = 1'b1;
    evt_ready = 1'b1;
    step(12);
    check("midrst_quiet_valid",  16'(evt_valid), 16'h0000);
    check("midrst_quiet_stable", 16'(sw_stable), 16'h0000);

    // Switch already high at reset release is reported as a normal event
    reset_reset_n = 1'b0;
    sw_raw = 8'h81;
    step(2);
    reset_reset_n = 1'b1;
    exp_q.push_back(16'h8181);
    step(5);
    check("rel_stable_early", 16'(sw_stable), 16'h0000);
    step(1);
    check("rel_stable", 16'(sw_stable), 16'h0081);
    wait_drain("rel_drain");

    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
